// File: rtl/usb4_tx_blk132_gearbox.sv
// 128b/132b Tx gearbox: packs 4-bit sync header + 4x32-bit payload blocks into a
// continuous 32-bit stream, presented as 40-bit PIPE words (8-of-10 lane layout).
module usb4_tx_blk132_gearbox #(
   parameter int HDR_W         = 4,
   parameter int WORDS_PER_BLK = 4,
   parameter int BUF_W         = 72
) (
   input  logic               i_pclk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [31:0]        i_in_data,
   input  logic               i_in_sob,
   input  logic [HDR_W-1:0]   i_in_hdr,
   input  logic               i_tx_idle_req,
   output logic [39:0]        o_pipe_tx_data,
   output logic               o_pipe_tx_data_valid,
   output logic [3:0]         o_pipe_tx_elec_idle,
   output logic               o_blk_err,
   output logic [6:0]         o_buf_level
);

   localparam int INS_W = 32 + HDR_W;
   localparam int WC_W  = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_BLK - 1);

   logic [BUF_W-1:0] r_buf;
   logic [6:0]       r_cnt;
   logic [WC_W-1:0]  r_wcnt;
   logic [39:0]      r_pipe_data;
   logic             r_pipe_valid;
   logic [3:0]       r_elec_idle;
   logic             r_blk_err;

   logic             w_pop;
   logic [7:0]       w_base;
   logic             w_in_ready;
   logic             w_acc;
   logic             w_ins_hdr;
   logic [INS_W-1:0] w_ins_data;
   logic [6:0]       w_ins_len;
   logic [BUF_W-1:0] w_shifted;
   logic [BUF_W-1:0] w_ins_ext;
   logic [39:0]      w_map;
   logic [WC_W-1:0]  w_wcnt_next;

   // Pop is decided on the registered fill; the shift lands before the insert.
   assign w_pop      = (r_cnt >= 7'd32);
   assign w_base     = {1'b0, r_cnt} - (w_pop ? 8'd32 : 8'd0);
   assign w_in_ready = !i_tx_idle_req && ((w_base + 8'(INS_W)) <= 8'(BUF_W));
   assign w_acc      = i_in_valid && w_in_ready;

   // A set in_sob always forces a block start, even when it arrives mid-block.
   assign w_ins_hdr  = i_in_sob || (r_wcnt == '0);
   assign w_ins_data = w_ins_hdr ? {i_in_data, i_in_hdr} : {{HDR_W{1'b0}}, i_in_data};
   assign w_ins_len  = w_ins_hdr ? 7'(INS_W) : 7'd32;
   assign w_shifted  = w_pop ? (r_buf >> 32) : r_buf;
   assign w_ins_ext  = {{(BUF_W-INS_W){1'b0}}, w_ins_data} << w_base;

   assign w_wcnt_next = w_ins_hdr ? WC_W'(1) :
                        ((r_wcnt == WC_LAST) ? '0 : r_wcnt + WC_W'(1));

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_map[gi*10 +: 10] = {2'b00, r_buf[gi*8 +: 8]};
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf        <= '0;
         r_cnt        <= '0;
         r_wcnt       <= '0;
         r_pipe_data  <= '0;
         r_pipe_valid <= 1'b0;
         r_elec_idle  <= 4'hF;
         r_blk_err    <= 1'b0;
      end else if (i_tx_idle_req) begin
         r_buf        <= '0;
         r_cnt        <= '0;
         r_wcnt       <= '0;
         r_pipe_valid <= 1'b0;
         r_elec_idle  <= 4'hF;
      end else begin
         r_buf <= w_acc ? (w_shifted | w_ins_ext) : w_shifted;
         r_cnt <= w_base[6:0] + (w_acc ? w_ins_len : 7'd0);
         if (w_acc) begin
            r_wcnt <= w_wcnt_next;
            if (i_in_sob != (r_wcnt == '0))
               r_blk_err <= 1'b1;
         end
         if (w_pop) begin
            r_pipe_data  <= w_map;
            r_pipe_valid <= 1'b1;
            r_elec_idle  <= 4'h0;
         end else begin
            r_pipe_valid <= 1'b0;
         end
      end
   end

   assign o_in_ready           = w_in_ready;
   assign o_pipe_tx_data       = r_pipe_data;
   assign o_pipe_tx_data_valid = r_pipe_valid;
   assign o_pipe_tx_elec_idle  = r_elec_idle;
   assign o_blk_err            = r_blk_err;
   assign o_buf_level          = r_cnt;

endmodule

// File: tb/tb_usb4_tx_blk132_gearbox.sv
// Randomized bench for usb4_tx_blk132_gearbox against a bit-queue serialiser model.
module tb_usb4_tx_blk132_gearbox;

   logic        i_pclk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [31:0] i_in_data = '0;
   logic        i_in_sob = 1'b0;
   logic [3:0]  i_in_hdr = '0;
   logic        i_tx_idle_req = 1'b0;
   logic [39:0] o_pipe_tx_data;
   logic        o_pipe_tx_data_valid;
   logic [3:0]  o_pipe_tx_elec_idle;
   logic        o_blk_err;
   logic [6:0]  o_buf_level;

   usb4_tx_blk132_gearbox dut (
      .i_pclk               (i_pclk),
      .i_rst_n              (i_rst_n),
      .i_in_valid           (i_in_valid),
      .o_in_ready           (o_in_ready),
      .i_in_data            (i_in_data),
      .i_in_sob             (i_in_sob),
      .i_in_hdr             (i_in_hdr),
      .i_tx_idle_req        (i_tx_idle_req),
      .o_pipe_tx_data       (o_pipe_tx_data),
      .o_pipe_tx_data_valid (o_pipe_tx_data_valid),
      .o_pipe_tx_elec_idle  (o_pipe_tx_elec_idle),
      .o_blk_err            (o_blk_err),
      .o_buf_level          (o_buf_level)
   );

   always #5 i_pclk = ~i_pclk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a plain FIFO of serial bits plus the block word position.
   bit          mq[$];
   int          m_wcnt;
   logic [39:0] m_data;
   logic        m_valid;
   logic [3:0]  m_idle;
   logic        m_err;

   bit          win_on = 0;
   int          win_cyc = 0;
   int          n_vld = 0;
   int          n_stall = 0;
   bit          watch_on = 0;
   logic [39:0] watch_mask;
   logic [39:0] watch_val;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [39:0] map32(input logic [31:0] d);
      return {2'b00, d[31:24], 2'b00, d[23:16], 2'b00, d[15:8], 2'b00, d[7:0]};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_wcnt  = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_idle  = 4'hF;
      m_err   = 1'b0;
   endtask

   // One clock: drive inputs, check in_ready before the edge, advance model, check outputs after.
   task automatic cycle(input logic v, input logic [31:0] d, input logic sob,
                        input logic [3:0] hdr, input logic idle, output bit acc);
      bit          pop;
      bit          rdy;
      bit          hins;
      logic [31:0] w;
      i_in_valid    = v;
      i_in_data     = d;
      i_in_sob      = sob;
      i_in_hdr      = hdr;
      i_tx_idle_req = idle;
      #1;
      pop = (mq.size() >= 32);
      rdy = !idle && ((mq.size() - (pop ? 32 : 0) + 36) <= 72);
      check_eq("in_ready", o_in_ready, rdy);
      acc = v && rdy;
      if (win_on && win_cyc >= 100 && win_cyc < 364 && !o_in_ready) n_stall++;
      @(posedge i_pclk);
      if (idle) begin
         mq.delete();
         m_wcnt  = 0;
         m_valid = 1'b0;
         m_idle  = 4'hF;
      end else begin
         if (pop) begin
            for (int i = 0; i < 32; i++) w[i] = mq.pop_front();
            m_data  = map32(w);
            m_valid = 1'b1;
            m_idle  = 4'h0;
         end else begin
            m_valid = 1'b0;
         end
         if (acc) begin
            hins = sob || (m_wcnt == 0);
            if (sob != (m_wcnt == 0)) m_err = 1'b1;
            if (hins) for (int i = 0; i < 4; i++) mq.push_back(hdr[i]);
            for (int i = 0; i < 32; i++) mq.push_back(d[i]);
            m_wcnt = hins ? 1 : (m_wcnt + 1) % 4;
         end
      end
      #1;
      check_eq("valid", o_pipe_tx_data_valid, m_valid);
      check_eq("data", o_pipe_tx_data, m_data);
      check_eq("elec_idle", o_pipe_tx_elec_idle, m_idle);
      check_eq("blk_err", o_blk_err, m_err);
      check_eq("buf_level", o_buf_level, mq.size());
      if (o_buf_level > 7'd72) check_eq("buf_level_max", o_buf_level, 72);
      if (win_on) begin
         if (win_cyc >= 100 && win_cyc < 364 && o_pipe_tx_data_valid) n_vld++;
         win_cyc++;
      end
      if (watch_on && o_pipe_tx_data_valid) begin
         check_eq("first_word", o_pipe_tx_data & watch_mask, watch_val);
         check_eq("first_elec_idle", o_pipe_tx_elec_idle, 0);
         watch_on = 0;
      end
   endtask

   task automatic send_block(input int nw, input logic [7:0] sobm, input logic [3:0] hdr,
                             input bit gap, input bit directed);
      bit          acc;
      int          tries;
      logic [31:0] d;
      logic [3:0]  h;
      for (int k = 0; k < nw; k++) begin
         d = directed ? (32'h11111111 * (k + 1)) : $urandom;
         h = (k == 0) ? hdr : 4'($urandom);
         tries = 0;
         do begin
            cycle(1'b1, d, sobm[k], h, 1'b0, acc);
            tries++;
         end while (!acc && tries < 20);
         if (!acc) check_eq("accept_timeout", o_in_ready, 1);
         if (gap) cycle(1'b0, $urandom, 1'b0, 4'($urandom), 1'b0, acc);
      end
   endtask

   initial begin
      bit acc;
      model_reset();
      #12;
      check_eq("rst_data", o_pipe_tx_data, 0);
      check_eq("rst_valid", o_pipe_tx_data_valid, 0);
      check_eq("rst_elec_idle", o_pipe_tx_elec_idle, 4'hF);
      check_eq("rst_blk_err", o_blk_err, 0);
      check_eq("rst_level", o_buf_level, 0);
      #1 i_rst_n = 1'b1;

      // Directed block: first PIPE word must be 0x1111111A.
      watch_mask = 40'hFF_FFFF_FFFF;
      watch_val  = map32(32'h1111111A);
      watch_on   = 1;
      send_block(4, 8'h01, 4'hA, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, acc);
      check_eq("lvl_after_4pops", o_buf_level, 4);
      check_eq("watch_done", watch_on, 0);

      // Continuous stream with metering window of 264 cycles.
      win_on = 1;
      for (int b = 0; b < 99; b++) send_block(4, 8'h01, 4'($urandom), 1'b0, 1'b0);
      win_on = 0;
      check_eq("win_valid_pulses", n_vld, 264);
      check_eq("win_ready_low", n_stall, 8);

      // Source gaps.
      for (int b = 0; b < 6; b++) send_block(4, 8'h01, 4'($urandom), 1'b1, 1'b0);

      // in_sob on the second word: resync, then clean blocks.
      send_block(5, 8'h03, 4'($urandom), 1'b0, 1'b0);
      check_eq("err_set", o_blk_err, 1);
      for (int b = 0; b < 3; b++) send_block(4, 8'h01, 4'($urandom), 1'b0, 1'b0);
      check_eq("err_sticky", o_blk_err, 1);

      // Idle pulse mid-block.
      send_block(2, 8'h01, 4'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, acc);
         check_eq("idle_elec", o_pipe_tx_elec_idle, 4'hF);
         check_eq("idle_valid", o_pipe_tx_data_valid, 0);
         check_eq("idle_level", o_buf_level, 0);
         check_eq("idle_ready", o_in_ready, 0);
      end
      watch_mask = 40'hF;
      watch_val  = 40'h5;
      watch_on   = 1;
      send_block(4, 8'h01, 4'h5, 1'b0, 1'b0);
      check_eq("watch_done2", watch_on, 0);
      send_block(4, 8'h01, 4'($urandom), 1'b1, 1'b0);

      // Async reset with 40 bits buffered.
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, acc);
      begin
         int k = 0;
         int n = 0;
         while (mq.size() != 40 && n < 20) begin
            cycle(1'b1, $urandom, (k == 0), 4'($urandom), 1'b0, acc);
            if (acc) k = (k + 1) % 4;
            n++;
         end
      end
      check_eq("lvl40", o_buf_level, 40);
      i_in_valid = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      check_eq("arst_data", o_pipe_tx_data, 0);
      check_eq("arst_valid", o_pipe_tx_data_valid, 0);
      check_eq("arst_elec_idle", o_pipe_tx_elec_idle, 4'hF);
      check_eq("arst_blk_err", o_blk_err, 0);
      check_eq("arst_level", o_buf_level, 0);
      model_reset();
      #3 i_rst_n = 1'b1;

      for (int b = 0; b < 2; b++) send_block(4, 8'h01, 4'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, acc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/usb4_tx_blk132_gearbox.md
Name: usb4_tx_blk132_gearbox

Overview:
Tx gearbox directly upstream of the USB4 PIPE Tx data-path mapper. Accepts 32-bit payload words with a 4-bit sync header per 128-bit block (128b/132b framing) and repacks the 132-bit blocks into a continuous 32-bit stream. The stream is presented as 40-bit PIPE words in the 8-of-10 lane layout the mapper extracts. The block meters the stream with pipe_tx_data_valid, throttles the source with in_ready, and drives electrical idle.

Parameters:
HDR_W, 4, sync-header width per block; fixed at 4, other values are unsupported.
WORDS_PER_BLK, 4, 32-bit payload words per block.
BUF_W, 72, bit-accumulator capacity; must be at least 32+32+HDR_W.

Ports:
pclk  input  1  PIPE clock; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  source word valid.
in_ready  output  1  gearbox can accept a word this cycle (combinational).
in_data  input  32  payload word; bit 0 is transmitted first.
in_sob  input  1  start of block; must be set on the first word of each block.
in_hdr  input  4  sync header; sampled only on the first word of a block.
tx_idle_req  input  1  request electrical idle.
pipe_tx_data  output  40  PIPE Tx word.
pipe_tx_data_valid  output  1  pipe_tx_data carries 32 new bits.
pipe_tx_elec_idle  output  4  electrical idle, replicated on all 4 bits.
blk_err  output  1  sticky framing error.
buf_level  output  7  current accumulator fill in bits (0..72).

Behaviour:
- Accumulator: buf[BUF_W-1:0] with fill counter cnt. Bit 0 is the oldest bit.
- Accept: a word is accepted when in_valid & in_ready at the clock edge.
- Word counter: wcnt runs 0..3 and increments on each accepted word, wrapping 3->0.
- Insert when wcnt==0: {in_data, in_hdr} (36 bits) is written at position cnt, with the header in the lower bits so it is sent first.
- Insert when wcnt!=0: in_data (32 bits) is written at position cnt.
- Framing check: in_sob must equal (wcnt==0); a mismatch sets blk_err (sticky until reset).
  - in_sob=1 with wcnt!=0: the word is treated as a block start (header inserted), and wcnt resyncs to 1.
  - in_sob=0 with wcnt==0: the header is still inserted from in_hdr.
- Pop: pop = (cnt>=32), evaluated on registered cnt.
  - On pop, the edge loads buf[31:0] into the output and shifts buf right by 32.
  - pipe_tx_data = {2'b0, d[31:24], 2'b0, d[23:16], 2'b0, d[15:8], 2'b0, d[7:0]}.
  - pipe_tx_data_valid <= 1.
- No pop: pipe_tx_data_valid <= 0 and pipe_tx_data holds its value.
- Same-edge pop and insert: the shift is applied before the insert. cnt_next = cnt - 32*pop + ins_len.
- in_ready = !tx_idle_req & (cnt - 32*pop + 36 <= BUF_W). It never depends on in_valid.
- Overflow is impossible by construction. cnt never exceeds 72 and is never negative.
- Latency: a first word accepted at edge N into an empty buffer appears with valid=1 after edge N+1.
- Steady-state metering: continuous in_valid gives 132 output words per 128 input words. in_ready is low for 4 cycles per 132-cycle period.
- Idle: while tx_idle_req=1 (registered effect at the edge):
  - cnt, buf and wcnt clear to 0 (partial data is discarded);
  - pipe_tx_data_valid <= 0 and pipe_tx_elec_idle <= 4'hF;
  - in_ready is low.
- Idle exit: after deassertion, pipe_tx_elec_idle <= 4'h0 at the first edge where pop occurs. The stream restarts at wcnt=0.
- Reset (async assert, sync-safe release):
  - pipe_tx_data=0, pipe_tx_data_valid=0, pipe_tx_elec_idle=4'hF;
  - blk_err=0, buf_level=0, cnt=0, wcnt=0.
  - Reset mid-block drops all buffered bits.
- buf_level = cnt (registered).

Test Plan:
- Reset, then one block (hdr=4'hA, words 0x11111111..0x44444444, sob on word 0): first valid PIPE word yields mapper data 0x1111111A; bits 135:132 of the 5th word's region are untouched; buf_level=4 after 4 pops.
- Continuous in_valid for 33 blocks: exactly 132 pipe_tx_data_valid pulses per 32 blocks; in_ready low 4 cycles per period; buf_level never >72; output bit sequence matches a reference 132-bit serialiser.
- Source gaps (in_valid toggling 1,0): pipe_tx_data_valid drops once cnt<32; no bit loss or duplication versus the model.
- in_sob on 2nd word of a block: blk_err=1 and stays set; header inserted at that word; the following blocks are correct.
- tx_idle_req pulse of 3 cycles mid-block: pipe_tx_elec_idle=4'hF, valid=0, buf_level=0, in_ready=0; after release, a new block with hdr=4'h5 gives 0x....5 as the first output nibble and elec_idle returns to 0 at that word.
- rst_n asserted asynchronously between edges with buf_level=40: outputs go to reset values immediately, without waiting for a clock edge.
